// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor.
// Holds the FSM state encoding and the counter-width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational add slice.
// Also reports the carry into its MSB so the caller can form signed overflow.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  assign s    = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // The MSB sum bit is x^y^carry_in, so the carry into it falls out directly.
  assign cmsb = x[CHUNK-1] ^ y[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/addsub_multicycle.sv
// WIDTH-bit add/subtract computed CHUNK bits per clock, LSB chunk first.
// start/busy/done handshake; a start seen in DONE chains straight into RUN.
module addsub_multicycle
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? clog2(N) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("addsub_multicycle: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state, nstate;
  logic [CW-1:0]    cnt;
  logic             carry, sub_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CHUNK-1:0] x, y, s;
  logic             c_out, c_msb, last, accept;
  int               idx;

  always_comb begin
    idx = int'(cnt) * CHUNK;
    x   = a_r[idx +: CHUNK];
    y   = sub_r ? ~b_r[idx +: CHUNK] : b_r[idx +: CHUNK];
  end

  assign last   = (cnt == CW'(N - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (x),
    .y    (y),
    .cin  (carry),
    .s    (s),
    .cout (c_out),
    .cmsb (c_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (last)  nstate = DONE;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      sub_r <= sub;
      cnt   <= '0;
      carry <= sub;  // +1 of the two's-complement negate rides in as carry-in
    end else if (state == RUN) begin
      sum[idx +: CHUNK] <= s;
      carry             <= c_out;
      cnt               <= cnt + 1'b1;
      if (last) begin
        cout <= c_out;
        ovf  <= c_msb ^ c_out;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_addsub_multicycle.sv
// Scoreboard bench: three instances (32/8, 16/16, 16/4) checked against an
// integer-arithmetic model with a cycle-accurate acceptance model.
module tb_addsub_multicycle;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    longint      edge_n;
  } exp_t;

  localparam int W [3] = '{32, 16, 16};
  localparam int N [3] = '{4, 1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        st [3];
  logic        sb [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        busyv [3];
  logic        donev [3];
  logic        coutv [3];
  logic        ovfv  [3];
  logic [31:0] sum0;
  logic [15:0] sum1, sum2;

  longint cyc = 0;
  longint free_e [3];
  exp_t   q0 [$];
  exp_t   q1 [$];
  exp_t   q2 [$];
  int     checks = 0;
  int     errs   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_multicycle #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .a(av[0]), .b(bv[0]),
    .busy(busyv[0]), .done(donev[0]), .sum(sum0), .cout(coutv[0]), .ovf(ovfv[0]));
  addsub_multicycle #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .a(av[1][15:0]), .b(bv[1][15:0]),
    .busy(busyv[1]), .done(donev[1]), .sum(sum1), .cout(coutv[1]), .ovf(ovfv[1]));
  addsub_multicycle #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .a(av[2][15:0]), .b(bv[2][15:0]),
    .busy(busyv[2]), .done(donev[2]), .sum(sum2), .cout(coutv[2]), .ovf(ovfv[2]));

  function automatic logic [31:0] get_sum(int d);
    case (d)
      0:       return sum0;
      1:       return {16'd0, sum1};
      default: return {16'd0, sum2};
    endcase
  endfunction

  // Reference: plain unsigned / signed integer arithmetic on w-bit values.
  function automatic exp_t model(int w, logic [31:0] x, logic [31:0] y, logic s);
    exp_t   e;
    longint m, hi, ux, uy, sx, sy, r, rs;
    m  = (longint'(1) << w) - 1;
    hi = longint'(1) << (w - 1);
    ux = longint'({32'd0, x}) & m;
    uy = longint'({32'd0, y}) & m;
    sx = (ux >= hi) ? ux - (m + 1) : ux;
    sy = (uy >= hi) ? uy - (m + 1) : uy;
    r  = s ? ux - uy : ux + uy;
    rs = s ? sx - sy : sx + sy;
    e.sum    = 32'(r & m);
    e.cout   = s ? (ux >= uy) : (ux + uy > m);
    e.ovf    = (rs >= hi) || (rs < -hi);
    e.edge_n = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_op(int w);
    logic [31:0] v, m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    case ($urandom_range(7))
      0:       v = 32'd0;
      1:       v = m;
      2:       v = m >> 1;
      3:       v = (m >> 1) + 1;
      4:       v = 32'd1;
      default: v = $urandom;
    endcase
    return v & m;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(int d, exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Called just after a negedge; the request is sampled at the next edge.
  // Accepted only when the DUT is idle or in its done cycle at that edge.
  task automatic drive(int d, logic [31:0] x, logic [31:0] y, logic s);
    exp_t   e;
    longint ne;
    st[d] = 1'b1; av[d] = x; bv[d] = y; sb[d] = s;
    ne = cyc + 1;
    if (!rst && ne >= free_e[d]) begin
      e        = model(W[d], x, y, s);
      e.edge_n = ne + N[d];
      push(d, e);
      free_e[d] = ne + N[d] + 1;
    end
  endtask

  task automatic idle_in(int d);
    st[d] = 1'b0;
    av[d] = $urandom;
    bv[d] = $urandom;
    sb[d] = 1'(($urandom_range(1)));
  endtask

  task automatic flush_all();
    q0.delete(); q1.delete(); q2.delete();
    for (int d = 0; d < 3; d++) free_e[d] = 0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while ((qsize(0) + qsize(1) + qsize(2)) > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);
  endtask

  task automatic chk_zero(string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_busy"}, {31'd0, busyv[d]}, 32'd0);
      chk({tag, "_done"}, {31'd0, donev[d]}, 32'd0);
      chk({tag, "_sum"},  get_sum(d), 32'd0);
      chk({tag, "_cout"}, {31'd0, coutv[d]}, 32'd0);
      chk({tag, "_ovf"},  {31'd0, ovfv[d]}, 32'd0);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (donev[d] === 1'b1) begin
          if (qsize(d) == 0) begin
            checks++; errs++;
            $display("FAIL unexpected_done dut%0d: done=1 at edge %0d, expected none", d, cyc);
          end else begin
            case (d)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            chk($sformatf("dut%0d_sum", d), get_sum(d), e.sum);
            chk($sformatf("dut%0d_cout", d), {31'd0, coutv[d]}, {31'd0, e.cout});
            chk($sformatf("dut%0d_ovf", d), {31'd0, ovfv[d]}, {31'd0, e.ovf});
            chk($sformatf("dut%0d_latency_edge", d), 32'(cyc), 32'(e.edge_n));
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; sb[d] = 1'b0; av[d] = '0; bv[d] = '0; free_e[d] = 0;
    end
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // First add: also check the busy window is exactly N cycles.
    @(negedge clk); drive(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_in(0);
      chk("busy_window", {31'd0, busyv[0]}, 32'd1);
    end
    @(negedge clk);
    chk("busy_after", {31'd0, busyv[0]}, 32'd0);
    wait_empty();

    @(negedge clk); drive(0, 32'hAAAA_AAAA, 32'h5555_5556, 1'b0); @(negedge clk); idle_in(0); wait_empty();
    @(negedge clk); drive(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0); @(negedge clk); idle_in(0); wait_empty();
    @(negedge clk); drive(0, 32'h0000_0000, 32'h0000_0001, 1'b1); @(negedge clk); idle_in(0); wait_empty();
    @(negedge clk); drive(0, 32'h8000_0000, 32'h0000_0001, 1'b1); @(negedge clk); idle_in(0); wait_empty();

    // start during RUN is ignored
    @(negedge clk); drive(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk); idle_in(0);
    @(negedge clk); drive(0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    @(negedge clk); idle_in(0);
    wait_empty();

    // start held high: second op taken in the DONE cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive(0, rand_op(32), rand_op(32), 1'(($urandom_range(1))));
    end
    @(negedge clk); idle_in(0);
    wait_empty();

    // reset in RUN cycle 2 drops the operation
    @(negedge clk); drive(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    @(negedge clk); idle_in(0);
    @(negedge clk); rst = 1'b1; flush_all();
    @(negedge clk); chk_zero("midrun_reset"); rst = 1'b0;
    repeat (10) @(negedge clk);
    @(negedge clk); drive(0, 32'h0000_00FF, 32'h0000_0001, 1'b0); @(negedge clk); idle_in(0); wait_empty();

    // start coincident with reset is dropped
    @(negedge clk); rst = 1'b1; drive(0, 32'h1, 32'h2, 1'b0);
    @(negedge clk); rst = 1'b0; idle_in(0);
    repeat (8) @(negedge clk);

    // single-chunk and 4-bit-chunk instances
    @(negedge clk); drive(1, 32'hFFFF, 32'h0001, 1'b0); @(negedge clk); idle_in(1); wait_empty();
    @(negedge clk); drive(2, 32'h7FFF, 32'h0001, 1'b0); @(negedge clk); idle_in(2); wait_empty();
    @(negedge clk); drive(2, 32'h0000, 32'h0001, 1'b1); @(negedge clk); idle_in(2); wait_empty();

    // random traffic on all instances; random holds exercise ignored and chained starts
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(2) == 0) drive(d, rand_op(W[d]), rand_op(W[d]), 1'(($urandom_range(1))));
        else idle_in(d);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) idle_in(d);
    wait_empty();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
